// File: rtl/multivar_cond_seq.sv
// rtl/multivar_cond_seq.sv - three-phase signed predicate sequencer with start delay and per-phase timeout
module multivar_cond_seq #(
  parameter int W           = 32,
  parameter int START_DELAY = 10,
  parameter int TIMEOUT     = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         cont,
  output logic [1:0]   phase,
  output logic         waiting,
  output logic         met,
  output logic         done,
  output logic         timeout_err
);

  typedef enum logic [2:0] {IDLE, DELAY, PH0, PH1, PH2, DONE, ERROR} state_t;

  localparam logic [15:0] DELAY_LAST   = 16'(START_DELAY - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [15:0]         cnt_q, cnt_d;
  logic signed [W-1:0] a_q, b_q, c_q;
  logic                cont_q, cont_d;
  logic                met_q, met_d;

  logic signed [W:0]   sum_ab, c_ext;
  logic                p0, p1, p2, pred;

  // One extra bit keeps a_q + b_q exact for the P1 comparison.
  assign sum_ab = {a_q[W-1], a_q} + {b_q[W-1], b_q};
  assign c_ext  = {c_q[W-1], c_q};

  assign p0 = a_q > b_q;
  assign p1 = sum_ab < c_ext;
  assign p2 = (a_q < b_q) && (b_q > c_q);

  always_comb begin
    case (state_q)
      PH0:     pred = p0;
      PH1:     pred = p1;
      PH2:     pred = p2;
      default: pred = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = 1'b0;
    met_d   = 1'b0;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = DELAY;
          cnt_d   = '0;
        end
      end
      DELAY: begin
        if (cnt_q == DELAY_LAST) begin
          state_d = PH0;
          cnt_d   = '0;
          cont_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      PH0, PH1, PH2: begin
        // A satisfied predicate wins over a timeout landing in the same cycle.
        if (pred) begin
          met_d = 1'b1;
          cnt_d = '0;
          if (state_q == PH2) begin
            state_d = DONE;
          end else begin
            state_d = (state_q == PH0) ? PH1 : PH2;
            cont_d  = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cont_q  <= 1'b0;
      met_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a;
      b_q     <= b;
      c_q     <= c;
      cont_q  <= cont_d;
      met_q   <= met_d;
    end
  end

  assign cont        = cont_q;
  assign met         = met_q;
  assign waiting     = (state_q == PH0) || (state_q == PH1) || (state_q == PH2);
  assign phase       = (state_q == PH1) ? 2'd1 : (state_q == PH2) ? 2'd2 : 2'd0;
  assign done        = (state_q == DONE);
  assign timeout_err = (state_q == ERROR);

endmodule

// File: tb/tb_multivar_cond_seq.sv
// tb/tb_multivar_cond_seq.sv - self-checking bench for multivar_cond_seq
module tb_multivar_cond_seq;

  localparam int W  = 32;
  localparam int SD = 10;
  localparam int TO = 16;

  localparam int M_IDLE = 0, M_DELAY = 1, M_PHASE = 2, M_DONE = 3, M_ERR = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0, c = '0;
  logic         cont, waiting, met, done, timeout_err;
  logic [1:0]   phase;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference: absolute-cycle timeline with 64-bit arithmetic predicates.
  int     m_mode = M_IDLE;
  int     m_ph = 0;
  int     m_entered = 0;
  int     m_ph0_at = 0;
  bit     m_cont = 1'b0, m_met = 1'b0;
  longint ra = 0, rb = 0, rc = 0;

  typedef struct {
    bit         r;
    bit         st;
    int         av;
    int         bv;
    int         cv;
    int         reps;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  multivar_cond_seq #(.W(W), .START_DELAY(SD), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
    .cont(cont), .phase(phase), .waiting(waiting), .met(met),
    .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_outs();
    return {cont, met, phase, waiting, done, timeout_err};
  endfunction

  function automatic logic [6:0] model_outs();
    logic [1:0] ph;
    ph = (m_mode == M_PHASE) ? 2'(m_ph) : 2'd0;
    return {m_cont, m_met, ph, m_mode == M_PHASE, m_mode == M_DONE, m_mode == M_ERR};
  endfunction

  function automatic bit pred(int n);
    case (n)
      0:       return ra > rb;
      1:       return (ra + rb) < rc;
      default: return (ra < rb) && (rb > rc);
    endcase
  endfunction

  task automatic check_vec(string name, logic [6:0] exp);
    checks++;
    if (dut_outs() !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%b expected=%b (cont met phase waiting done err)",
               name, cyc, dut_outs(), exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    bit     st, r, p;
    longint ia, ib, ic;
    st = start;
    r  = rst;
    ia = longint'($signed(a));
    ib = longint'($signed(b));
    ic = longint'($signed(c));
    @(posedge clk);
    cyc++;
    m_cont = 1'b0;
    m_met  = 1'b0;
    if (r) begin
      m_mode = M_IDLE;
      m_ph   = 0;
    end else begin
      p = pred(m_ph);
      case (m_mode)
        M_DELAY: begin
          if (cyc == m_ph0_at) begin
            m_mode = M_PHASE; m_ph = 0; m_entered = cyc; m_cont = 1'b1;
          end
        end
        M_PHASE: begin
          if (p) begin
            m_met = 1'b1;
            if (m_ph == 2) m_mode = M_DONE;
            else begin m_ph++; m_entered = cyc; m_cont = 1'b1; end
          end else if (cyc - m_entered == TO) begin
            m_mode = M_ERR;
          end
        end
        default: begin
          if (st) begin m_mode = M_DELAY; m_ph0_at = cyc + SD; end
        end
      endcase
    end
    if (r) begin ra = 0; rb = 0; rc = 0; end
    else begin ra = ia; rb = ib; rc = ic; end
    #1;
    check_vec("model", model_outs());
  endtask

  task automatic wait_cont(string name, output int at);
    bit seen;
    seen = 1'b0;
    at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (cont) begin seen = 1'b1; at = cyc; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s no cont within 40 cycles got=none expected=cont", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, t0;

    tbl.push_back('{1, 1, 0, 0, 0, 2, 7'b0000000});
    tbl.push_back('{0, 1, 0, 0, 0, 1, 7'b0000000});
    tbl.push_back('{0, 0, 0, 0, 0, 9, 7'b0000000});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 7'b1000100});
    tbl.push_back('{0, 0, 0, 1, 0, 1, 7'b0000100});
    tbl.push_back('{0, 0, 2, 1, 0, 1, 7'b0000100});
    tbl.push_back('{0, 0, 2, 1, 0, 1, 7'b1101100});
    tbl.push_back('{0, 0, 2, 1, 3, 2, 7'b0001100});
    tbl.push_back('{0, 0, 2, 1, 4, 2, 7'b1110100});
    tbl.push_back('{0, 0, 2, 5, 4, 2, 7'b0100010});
    tbl.push_back('{0, 0, 2, 5, 4, 1, 7'b0000010});
    tbl.push_back('{1, 0, 2, 5, 4, 1, 7'b0000000});

    #1;
    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].st;
      a = tbl[i].av; b = tbl[i].bv; c = tbl[i].cv;
      repeat (tbl[i].reps) step();
      check_vec($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Predicates already true on entry: P0 and P1 fire back to back, P2 stalls.
    rst = 1'b1; start = 1'b0; a = 2; b = 1; c = 9; step();
    rst = 1'b0; start = 1'b1; step(); t0 = cyc;
    start = 1'b0;
    wait_cont("imm_cont", at);
    check_int("imm_latency", at - t0, SD);
    step(); check_vec("imm_p0", 7'b1101100);
    step(); check_vec("imm_p1", 7'b1110100);
    repeat (3) step();
    check_vec("imm_stall", 7'b0010100);

    // Timeout in PH0 then restart clears the sticky error.
    rst = 1'b1; a = 0; b = 0; c = 0; step();
    rst = 1'b0; start = 1'b1; step(); start = 1'b0;
    wait_cont("to_cont", at);
    repeat (TO - 1) step();
    check_vec("to_before", 7'b0000100);
    step();
    check_vec("to_err", 7'b0000001);
    check_int("to_cycles", cyc - at, TO);
    start = 1'b1; step(); t0 = cyc; start = 1'b0;
    check_vec("to_clear", 7'b0000000);
    wait_cont("to_restart", at);
    check_int("to_restart_latency", at - t0, SD);

    // Signed overflow handling in PH1.
    rst = 1'b1; step();
    rst = 1'b0; a = 2; b = 1; c = 0; start = 1'b1; step(); start = 1'b0;
    wait_cont("ovf_cont", at);
    step(); check_vec("ovf_ph1", 7'b1101100);
    a = 32'h7FFF_FFFF; b = 1; c = 32'hFFFF_FFFF;
    repeat (3) begin step(); check_vec("ovf_nomet", 7'b0001100); end
    a = -5; b = 1; c = 0;
    step(); check_vec("ovf_wait", 7'b0001100);
    step(); check_vec("ovf_met", 7'b1110100);

    // Start ignored in PH0, reset mid-PH1, restart right after reset.
    rst = 1'b1; step();
    rst = 1'b0; a = 0; b = 0; c = 0; start = 1'b1; step(); start = 1'b0;
    wait_cont("mid_cont", at);
    start = 1'b1; step(); start = 1'b0;
    check_vec("mid_ignore", 7'b0000100);
    a = 2; b = 1; step(); step();
    check_vec("mid_ph1", 7'b1101100);
    rst = 1'b1; step();
    check_vec("mid_rst", 7'b0000000);
    rst = 1'b0; start = 1'b1; step(); t0 = cyc; start = 1'b0;
    wait_cont("mid_restart", at);
    check_int("mid_restart_latency", at - t0, SD);

    // Randomised traffic against the reference timeline.
    rst = 1'b1; step();
    for (int i = 0; i < 2000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        a = ($urandom_range(0, 19) == 0) ? $urandom() : 32'(int'($urandom_range(0, 6)) - 3);
      if ($urandom_range(0, 3) == 0)
        b = ($urandom_range(0, 19) == 0) ? $urandom() : 32'(int'($urandom_range(0, 6)) - 3);
      if ($urandom_range(0, 3) == 0)
        c = ($urandom_range(0, 19) == 0) ? $urandom() : 32'(int'($urandom_range(0, 6)) - 3);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multivar_cond_seq.md
MULTIVAR_COND_SEQ -- requirements
Module: multivar_cond_seq

Interface
REQ-001 SHALL provide parameter W, default 32: operand width in bits; operands are two's-complement signed.
REQ-002 SHALL provide parameter START_DELAY, default 10: cycles from start acceptance to phase 0 entry; legal range 1..255.
REQ-003 SHALL provide parameter TIMEOUT, default 1000: maximum cycles spent in any one phase; legal range 2..65535.
REQ-004 SHALL provide port clk, input, 1 bit: sole clock; all state is updated on the rising edge.
REQ-005 SHALL provide port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL provide port start, input, 1 bit: request to begin a sequence.
REQ-007 SHALL provide ports a, b, c, input, W bits each: signed operands.
REQ-008 SHALL provide port cont, output, 1 bit: one-cycle pulse on entry to each wait phase.
REQ-009 SHALL provide port phase, output, 2 bits: current wait phase, 0..2.
REQ-010 SHALL provide port waiting, output, 1 bit: high in any wait phase.
REQ-011 SHALL provide port met, output, 1 bit: one-cycle pulse when the current phase predicate is satisfied.
REQ-012 SHALL provide port done, output, 1 bit: sticky; all three predicates satisfied.
REQ-013 SHALL provide port timeout_err, output, 1 bit: sticky; a phase exceeded TIMEOUT.

Function
REQ-014 SHALL use the states IDLE, DELAY, PH0, PH1, PH2, DONE and ERROR.
REQ-015 SHALL register a, b and c every cycle into a_q, b_q and c_q; predicates SHALL use only the registered copies, giving 1 cycle of input latency.
REQ-016 SHALL define the predicates as: P0 = a_q > b_q; P1 = a_q + b_q < c_q; P2 = (a_q < b_q) && (b_q > c_q).
REQ-017 SHALL compute all predicate comparisons as signed, and SHALL form the P1 sum at W+1 bits so that no wrap-around occurs.
REQ-018 SHALL accept start only in IDLE, DONE or ERROR; acceptance SHALL clear done and timeout_err and move to DELAY on the next edge with the delay counter at 0.
REQ-019 SHALL ignore start in DELAY, PH0, PH1 and PH2.
REQ-020 SHALL move from DELAY to PH0 after exactly START_DELAY cycles in DELAY, so that cont is high in the cycle start-sample-edge + 1 + START_DELAY.
REQ-021 SHALL, while in PHn, set the next state on the next edge when Pn is true: PH(n+1) for n < 2, or DONE for n = 2.
REQ-022 SHALL drive met = 1 for exactly that next cycle.
REQ-023 SHALL, when the next state is PH1 or PH2, drive cont = 1 in that same cycle as met, with phase updated in that cycle.
REQ-024 SHALL treat a predicate that is already true on phase entry as satisfied, with met asserted 1 cycle after that phase's cont.
REQ-025 SHALL advance at most one phase per cycle.
REQ-026 SHALL clear the per-phase cycle counter on every phase entry.
REQ-027 SHALL move to ERROR on the next edge when Pn is false and the counter equals TIMEOUT-1.
REQ-028 SHALL give the predicate priority when the predicate becomes true in the same cycle as the timeout, advancing instead of entering ERROR.
REQ-029 SHALL keep done = 1 in DONE and timeout_err = 1 in ERROR until start acceptance or rst.
REQ-030 SHALL drive waiting = 1 only in PH0, PH1 and PH2.
REQ-031 SHALL drive phase = 0 in every state other than PH0, PH1 and PH2.
REQ-032 SHALL never assert cont outside phase entry, and SHALL never assert met and timeout_err together.

Reset
REQ-033 SHALL, while rst = 1 at an edge, force state IDLE, all counters 0, a_q = b_q = c_q = 0, and every output 0.
REQ-034 SHALL give rst priority over start and over any in-progress phase, including a reset applied mid-phase.
REQ-035 SHALL accept start in the first cycle after rst deasserts.

Verification
REQ-036 Reset: assert rst for 2 cycles with start = 1 -> all outputs 0, state IDLE; start is not accepted while rst is high.
REQ-037 Nominal, defaults, start at cycle 0 -> cont at cycle 11.
- Drive b = 1, then a = 2 -> met plus cont with phase = 1.
- Drive c = 3 -> no met, since 3 < 3 is false.
- Drive c = 4 -> met plus cont with phase = 2.
- Drive b = 5 -> met, then done = 1 and waiting = 0.
REQ-038 Immediate predicate: hold a = 2, b = 1, c = 9 before start -> P0 then P1 met on consecutive cycles after the first cont; stalls in PH2.
REQ-039 Timeout: TIMEOUT = 16, hold a = b = c = 0 -> timeout_err = 1 exactly 16 cycles after the PH0 cont, done = 0; a later start clears it and restarts.
REQ-040 Signed/overflow:
- In PH1, drive a = 0x7FFFFFFF, b = 1, c = -1 -> P1 false, no met.
- Then drive a = -5, b = 1, c = 0 -> met.
REQ-041 Mid-operation reset: rst pulsed in PH1 -> next cycle all outputs 0; start 1 cycle later -> cont START_DELAY + 1 cycles after that; start pulsed during PH0 -> ignored.
